// File: rtl/fetch_core.sv
// rtl/fetch_core.sv - SLC-3 style instruction fetch datapath and controller
module fetch_core #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    MEM_WAIT    = 1,
    parameter int                    STEP_MODE   = 1,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run_i,
    input  logic                   continue_i,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic                   mem_mem_ena,
    output logic                   mem_wr_ena,
    output logic [ADDR_WIDTH-1:0]  pc_o,
    output logic [DATA_WIDTH-1:0]  ir_o,
    output logic [DATA_WIDTH-1:0]  led_o,
    output logic [DATA_WIDTH-1:0]  hex_display_debug,
    output logic                   halted_o,
    output logic                   paused_o,
    output logic [COUNT_WIDTH-1:0] fetch_count_o
);

    // Wait counter only has to reach MEM_WAIT-1; keep it at least one bit wide.
    localparam int                WAIT_W    = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT - 1);

    typedef enum logic [2:0] {
        S_HALTED,
        S_18,
        S_33,
        S_35,
        S_PAUSE
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [ADDR_WIDTH-1:0]  pc_q;
    logic [ADDR_WIDTH-1:0]  mar_q;
    logic [DATA_WIDTH-1:0]  mdr_q;
    logic [DATA_WIDTH-1:0]  ir_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [WAIT_W-1:0]      wait_q;
    logic                   run_q;
    logic                   cont_q;
    logic                   run_rise;
    logic                   cont_rise;
    logic                   wait_done;

    // A held level yields a single event: only low-to-high transitions count.
    assign run_rise  = run_i & ~run_q;
    assign cont_rise = continue_i & ~cont_q;
    assign wait_done = (wait_q == WAIT_LAST);

    // Previous-cycle copies of the buttons for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q  <= 1'b0;
            cont_q <= 1'b0;
        end else begin
            run_q  <= run_i;
            cont_q <= continue_i;
        end
    end

    // Fetch state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_HALTED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; edges arriving in a state that does not accept them are dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HALTED: if (run_rise) state_d = S_18;
            S_18:     state_d = S_33;
            S_33:     if (wait_done) state_d = S_35;
            S_35:     state_d = (STEP_MODE != 0) ? S_PAUSE : S_18;
            S_PAUSE:  if (cont_rise) state_d = S_18;
            default:  state_d = S_HALTED;
        endcase
    end

    // Memory wait counter: zero outside S_33, so every S_33 visit starts from zero.
    always_ff @(posedge clk) begin
        if (reset || state_q != S_33 || wait_done) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_q + WAIT_W'(1);
        end
    end

    // PC/MAR/MDR/IR and fetch counter updates driven by the fetch phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            mar_q   <= '0;
            mdr_q   <= '0;
            ir_q    <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                S_18: begin
                    mar_q <= pc_q;
                    pc_q  <= pc_q + ADDR_WIDTH'(1);
                end
                S_33: begin
                    if (wait_done) mdr_q <= mem_rdata;
                end
                S_35: begin
                    ir_q    <= mdr_q;
                    count_q <= count_q + COUNT_WIDTH'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr          = mar_q;
    assign mem_wdata         = mdr_q;
    assign mem_mem_ena       = (state_q == S_33);
    assign mem_wr_ena        = 1'b0;
    assign pc_o              = pc_q;
    assign ir_o              = ir_q;
    assign led_o             = ir_q;
    assign hex_display_debug = ir_q;
    assign halted_o          = (state_q == S_HALTED);
    assign paused_o          = (state_q == S_PAUSE);
    assign fetch_count_o     = count_q;

endmodule

// File: tb/tb_fetch_core.sv
// tb/tb_fetch_core.sv - randomized model-checked bench for fetch_core
module tb_fetch_core;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        run   [N];
    logic        cont  [N];
    logic        rst   [N];
    logic [15:0] rd_w  [N];
    logic [15:0] junk  [N];
    logic [15:0] wd_w  [N];
    logic [15:0] addr_w[N];
    logic        ena_w [N];
    logic        wr_w  [N];
    logic [15:0] pc_w  [N];
    logic [15:0] ir_w  [N];
    logic [15:0] led_w [N];
    logic [15:0] hex_w [N];
    logic        hlt_w [N];
    logic        pau_w [N];
    logic [15:0] cnt_w [N];

    int          mw_p [N] = '{1, 3, 2};
    int          st_p [N] = '{1, 0, 1};
    logic [15:0] rpc_p[N] = '{16'h0000, 16'h0000, 16'hFFFF};

    int total = 0;
    int bad   = 0;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    // Memory only guarantees data while enabled; otherwise present garbage.
    for (genvar g = 0; g < N; g++) begin : g_mem
        assign rd_w[g] = ena_w[g] ? memf(addr_w[g]) : junk[g];
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) junk[i] = 16'($urandom);
    end

    fetch_core #(.MEM_WAIT(1), .STEP_MODE(1), .RESET_PC(16'h0000)) u_a (
        .clk(clk), .reset(rst[0]), .run_i(run[0]), .continue_i(cont[0]),
        .mem_rdata(rd_w[0]), .mem_wdata(wd_w[0]), .mem_addr(addr_w[0]),
        .mem_mem_ena(ena_w[0]), .mem_wr_ena(wr_w[0]), .pc_o(pc_w[0]),
        .ir_o(ir_w[0]), .led_o(led_w[0]), .hex_display_debug(hex_w[0]),
        .halted_o(hlt_w[0]), .paused_o(pau_w[0]), .fetch_count_o(cnt_w[0]));

    fetch_core #(.MEM_WAIT(3), .STEP_MODE(0), .RESET_PC(16'h0000)) u_b (
        .clk(clk), .reset(rst[1]), .run_i(run[1]), .continue_i(cont[1]),
        .mem_rdata(rd_w[1]), .mem_wdata(wd_w[1]), .mem_addr(addr_w[1]),
        .mem_mem_ena(ena_w[1]), .mem_wr_ena(wr_w[1]), .pc_o(pc_w[1]),
        .ir_o(ir_w[1]), .led_o(led_w[1]), .hex_display_debug(hex_w[1]),
        .halted_o(hlt_w[1]), .paused_o(pau_w[1]), .fetch_count_o(cnt_w[1]));

    fetch_core #(.MEM_WAIT(2), .STEP_MODE(1), .RESET_PC(16'hFFFF)) u_c (
        .clk(clk), .reset(rst[2]), .run_i(run[2]), .continue_i(cont[2]),
        .mem_rdata(rd_w[2]), .mem_wdata(wd_w[2]), .mem_addr(addr_w[2]),
        .mem_mem_ena(ena_w[2]), .mem_wr_ena(wr_w[2]), .pc_o(pc_w[2]),
        .ir_o(ir_w[2]), .led_o(led_w[2]), .hex_display_debug(hex_w[2]),
        .halted_o(hlt_w[2]), .paused_o(pau_w[2]), .fetch_count_o(cnt_w[2]));

    // Model: mode 0 idle, 1 fetching, 2 waiting for continue.
    // k is the cycle index inside one fetch: 0 address, 1..mw memory, mw+1 IR load.
    typedef struct {
        int          mode;
        int          k;
        logic [15:0] pc;
        logic [15:0] mar;
        logic [15:0] mdr;
        logic [15:0] ir;
        logic [15:0] cnt;
        logic        pr;
        logic        pcn;
    } model_t;

    model_t m     [N];
    bit     valid [N] = '{0, 0, 0};

    function automatic model_t step_m(input model_t cur, input logic r, input logic c,
                                      input logic rs, input int mw, input int st,
                                      input logic [15:0] rpc);
        model_t n = cur;
        if (rs) begin
            n.mode = 0; n.k = 0; n.pc = rpc; n.mar = 0; n.mdr = 0;
            n.ir = 0; n.cnt = 0; n.pr = 0; n.pcn = 0;
            return n;
        end
        n.pr  = r;
        n.pcn = c;
        if (cur.mode == 0) begin
            if (r && !cur.pr) begin n.mode = 1; n.k = 0; end
        end else if (cur.mode == 2) begin
            if (c && !cur.pcn) begin n.mode = 1; n.k = 0; end
        end else begin
            n.k = cur.k + 1;
            if (cur.k == 0) begin
                n.mar = cur.pc;
                n.pc  = cur.pc + 16'd1;
            end
            if (cur.k == mw) n.mdr = memf(cur.mar);
            if (cur.k == mw + 1) begin
                n.ir  = cur.mdr;
                n.cnt = cur.cnt + 16'd1;
                n.k   = 0;
                if (st != 0) n.mode = 2;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            m[i] = step_m(m[i], run[i], cont[i], rst[i], mw_p[i], st_p[i], rpc_p[i]);
            if (rst[i]) valid[i] = 1'b1;
        end
    end

    task automatic chk(input string nm, input int inst, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] actual=%h required=%h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    // Every cycle, every instance's outputs against the model.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (valid[i]) begin
                chk("pc", i, pc_w[i], m[i].pc);
                chk("ir", i, ir_w[i], m[i].ir);
                chk("led", i, led_w[i], m[i].ir);
                chk("hex", i, hex_w[i], m[i].ir);
                chk("count", i, cnt_w[i], m[i].cnt);
                chk("addr", i, addr_w[i], m[i].mar);
                chk("wdata", i, wd_w[i], m[i].mdr);
                chk("ena", i, 16'(ena_w[i]),
                    16'(m[i].mode == 1 && m[i].k >= 1 && m[i].k <= mw_p[i]));
                chk("wr_ena", i, 16'(wr_w[i]), 16'h0);
                chk("halted", i, 16'(hlt_w[i]), 16'(m[i].mode == 0));
                chk("paused", i, 16'(pau_w[i]), 16'(m[i].mode == 2));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    int          ena_n;
    logic [15:0] ena_addr;
    bit          seen;

    initial begin
        for (int i = 0; i < N; i++) begin
            run[i] = 0; cont[i] = 0; rst[i] = 1;
        end
        cyc(2);
        for (int i = 0; i < N; i++) rst[i] = 0;

        // Reset state, then idle with buttons low.
        chk("lit_rst_halted", 0, 16'(hlt_w[0]), 16'h1);
        chk("lit_rst_pc", 0, pc_w[0], 16'h0000);
        chk("lit_rst_ir", 0, ir_w[0], 16'h0000);
        chk("lit_rst_cnt", 0, cnt_w[0], 16'h0000);
        chk("lit_rst_ena", 0, 16'(ena_w[0]), 16'h0);
        chk("lit_rst_pc", 2, pc_w[2], 16'hFFFF);
        cyc(10);
        chk("lit_idle_halted", 0, 16'(hlt_w[0]), 16'h1);
        chk("lit_idle_pc", 0, pc_w[0], 16'h0000);

        // Single-step fetch with one wait state.
        run[0] = 1; cyc(1); run[0] = 0;
        ena_n = 0; ena_addr = 16'hDEAD;
        for (int j = 0; j < 10; j++) begin
            if (ena_w[0]) begin ena_n++; ena_addr = addr_w[0]; end
            if (j == 2) chk("lit_ir_early", 0, ir_w[0], 16'h0000);
            if (j == 3) begin
                chk("lit_ir1", 0, ir_w[0], 16'hA5A5);
                chk("lit_pc1", 0, pc_w[0], 16'h0001);
                chk("lit_paused1", 0, 16'(pau_w[0]), 16'h1);
                chk("lit_cnt1", 0, cnt_w[0], 16'h0001);
            end
            cyc(1);
        end
        chk("lit_ena_cycles", 0, 16'(ena_n), 16'd1);
        chk("lit_ena_addr", 0, ena_addr, 16'h0000);

        // Held continue gives one fetch; a fresh press gives another.
        cont[0] = 1; cyc(20); cont[0] = 0;
        chk("lit_ir2", 0, ir_w[0], 16'hA5A4);
        chk("lit_pc2", 0, pc_w[0], 16'h0002);
        chk("lit_cnt2", 0, cnt_w[0], 16'h0002);
        cyc(2); cont[0] = 1; cyc(1); cont[0] = 0; cyc(6);
        chk("lit_ir3", 0, ir_w[0], 16'hA5A7);
        chk("lit_pc3", 0, pc_w[0], 16'h0003);

        // Free-running, three wait states, continue toggling is irrelevant.
        run[1] = 1; cyc(1); run[1] = 0;
        ena_n = 0;
        for (int j = 0; j < 20; j++) begin
            cont[1] = 1'($urandom_range(0, 1));
            if (ena_w[1]) ena_n++;
            cyc(1);
        end
        cont[1] = 0;
        chk("lit_free_cnt", 1, cnt_w[1], 16'd4);
        chk("lit_free_pc", 1, pc_w[1], 16'd4);
        chk("lit_free_ena", 1, 16'(ena_n), 16'd12);

        // Reset in the second S_33 cycle, with a coincident run pulse.
        seen = 0;
        for (int j = 0; j < 20 && !seen; j++) begin
            if (!ena_w[1]) seen = 1; else cyc(1);
        end
        chk("lit_wait_low", 1, 16'(seen), 16'h1);
        seen = 0;
        for (int j = 0; j < 20 && !seen; j++) begin
            if (ena_w[1]) seen = 1; else cyc(1);
        end
        chk("lit_wait_high", 1, 16'(seen), 16'h1);
        cyc(1);
        chk("lit_second_s33", 1, 16'(ena_w[1]), 16'h1);
        rst[1] = 1; run[1] = 1; cyc(1); rst[1] = 0; run[1] = 0;
        chk("lit_mid_halted", 1, 16'(hlt_w[1]), 16'h1);
        chk("lit_mid_ena", 1, 16'(ena_w[1]), 16'h0);
        chk("lit_mid_pc", 1, pc_w[1], 16'h0000);
        chk("lit_mid_ir", 1, ir_w[1], 16'h0000);
        chk("lit_mid_cnt", 1, cnt_w[1], 16'h0000);
        cyc(5);
        chk("lit_mid_still_halted", 1, 16'(hlt_w[1]), 16'h1);

        // PC wrap from 0xFFFF.
        run[2] = 1; cyc(1); run[2] = 0;
        ena_addr = 16'hDEAD; seen = 0;
        for (int j = 0; j < 8; j++) begin
            if (ena_w[2] && !seen) begin ena_addr = addr_w[2]; seen = 1; end
            cyc(1);
        end
        chk("lit_wrap_addr", 2, ena_addr, 16'hFFFF);
        chk("lit_wrap_pc", 2, pc_w[2], 16'h0000);
        chk("lit_wrap_ir", 2, ir_w[2], 16'h5A5A);
        chk("lit_wrap_paused", 2, 16'(pau_w[2]), 16'h1);
        cont[2] = 1; cyc(1); cont[2] = 0;
        ena_addr = 16'hDEAD; seen = 0;
        for (int j = 0; j < 8; j++) begin
            if (ena_w[2] && !seen) begin ena_addr = addr_w[2]; seen = 1; end
            cyc(1);
        end
        chk("lit_after_wrap_addr", 2, ena_addr, 16'h0000);
        chk("lit_after_wrap_ir", 2, ir_w[2], 16'hA5A5);
        chk("lit_after_wrap_pc", 2, pc_w[2], 16'h0001);

        // Random buttons and occasional resets against the model.
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) run[i] = ~run[i];
                if ($urandom_range(0, 5) == 0) cont[i] = ~cont[i];
                rst[i] = ($urandom_range(0, 199) == 0);
            end
            cyc(1);
        end
        for (int i = 0; i < N; i++) begin
            run[i] = 0; cont[i] = 0; rst[i] = 0;
        end
        cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_core.md
Name: fetch_core

Overview:
- Parametrised instruction-fetch datapath and controller for the SLC-3 style CPU.
- Owns the PC, MAR, MDR and IR registers and a fetch FSM (states 18 -> 33 -> 35).
- Adds three things to the single-width, fixed-timing fetch path: configurable memory wait states, run-to-free or single-step mode, and a fetch counter.
- Sits between the top-level run/continue buttons and the synchronous on-chip memory; it is the base the decode/execute stages will later attach to.

Parameters:
DATA_WIDTH, 16, width of MDR, IR, mem_rdata, mem_wdata, led_o, hex_display_debug
ADDR_WIDTH, 16, width of PC, MAR, mem_addr
MEM_WAIT, 1, number of cycles mem_mem_ena is held before mem_rdata is valid (>=1)
STEP_MODE, 1, 1 = pause after every fetch until continue_i; 0 = free-running
RESET_PC, 0, PC value loaded at reset (ADDR_WIDTH bits)
COUNT_WIDTH, 16, width of fetch_count_o

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
run_i  input  1  level; rising edge starts fetching from HALTED
continue_i  input  1  level; rising edge releases PAUSE
mem_rdata  input  DATA_WIDTH  read data from memory
mem_wdata  output  DATA_WIDTH  always equal to MDR
mem_addr  output  ADDR_WIDTH  always equal to MAR
mem_mem_ena  output  1  memory enable; high in all S_33 cycles only
mem_wr_ena  output  1  write enable; constant 0
pc_o  output  ADDR_WIDTH  current PC
ir_o  output  DATA_WIDTH  current IR
led_o  output  DATA_WIDTH  equals IR
hex_display_debug  output  DATA_WIDTH  equals IR
halted_o  output  1  high in HALTED
paused_o  output  1  high in PAUSE
fetch_count_o  output  COUNT_WIDTH  number of completed fetches (IR loads)

Behaviour:
- Reset (synchronous, has priority over everything, valid in any state including mid-fetch):
  - state = HALTED; PC = RESET_PC; MAR = MDR = IR = 0; fetch_count = 0; edge-detect registers = 0.
  - All enables low.
- Edge detection: the rising edge of run_i or continue_i is current = 1 with the previous-cycle registered value = 0. A held level produces one event only.
- FSM states and actions:
  - HALTED: idle. On a run_i rising edge -> S_18. continue_i is ignored. If run_i and continue_i rise together, run wins.
  - S_18 (1 cycle): MAR <= PC; PC <= PC + 1, wrapping modulo 2^ADDR_WIDTH. -> S_33.
  - S_33 (MEM_WAIT cycles, counted by an internal wait counter cleared on entry): mem_mem_ena = 1, mem_addr = MAR. On the last cycle MDR <= mem_rdata. -> S_35.
  - S_35 (1 cycle): IR <= MDR; fetch_count <= fetch_count + 1, wrapping. -> PAUSE if STEP_MODE = 1, else -> S_18.
  - PAUSE: holds all registers. On a continue_i rising edge -> S_18. run_i is ignored.
- Edges that arrive outside their accepting state are dropped, not queued.
- Timing:
  - Fetch latency from S_18 entry to IR valid is MEM_WAIT + 2 cycles; IR updates at the end of S_35.
  - Free-running throughput is one instruction per MEM_WAIT + 2 cycles.
  - The first S_18 begins the cycle after the run edge is sampled.
- Memory contract: the synchronous memory presents data for mem_addr while mem_mem_ena is high. MEM_WAIT = 1 means data is valid in the same cycle as the single S_33 cycle.
- mem_wr_ena is never asserted; mem_wdata is driven but unused.

Test Plan:
1. Reset with RESET_PC = 0x0000 -> halted_o = 1, pc_o = 0, ir_o = 0, fetch_count_o = 0, mem_mem_ena = 0; run_i and continue_i held at 0 for 10 cycles -> no change.
2. MEM_WAIT = 1, STEP_MODE = 1, mem[a] = a ^ 0xA5A5, pulse run_i:
   - mem_mem_ena is high for exactly 1 cycle with mem_addr = 0.
   - ir_o = 0xA5A5 three cycles after S_18 entry; pc_o = 1; paused_o = 1; fetch_count_o = 1.
3. From PAUSE, continue_i held high for 20 cycles -> exactly one further fetch: ir_o = 0xA5A4, pc_o = 2, count = 2. Release and re-press -> ir_o = 0xA5A7, pc_o = 3.
4. STEP_MODE = 0, MEM_WAIT = 3, pulse run_i -> mem_mem_ena is high 3 cycles per fetch, a new IR every 5 cycles; after 4 fetches pc_o = 4 and fetch_count_o = 4; continue_i toggling has no effect.
5. RESET_PC = 0xFFFF, STEP_MODE = 1 -> first fetch reads mem_addr = 0xFFFF and pc_o wraps to 0x0000; the next continue fetches address 0x0000.
6. Assert reset during the second S_33 cycle with MEM_WAIT = 3 -> the next cycle shows halted_o = 1, mem_mem_ena = 0, pc_o = RESET_PC, ir_o = 0, count = 0; a run_i edge sampled in the same cycle as reset is ignored.
